// File: rtl/freq_entry_controller.sv
// freq_entry_controller
//   Collects up to seven keypad digits into a BCD register. On commit it waits
//   CONV_LATENCY cycles for the external BCD-to-binary converter to settle. It
//   then samples and range-checks the result. An accepted value is presented to
//   the NCO with a one-cycle freq_load strobe.
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   digit_valid/digit_in  keypad digit strobe and BCD value
//   clear, commit         discard entry / convert-and-apply strobes
//   d_1..d_7              BCD digits to converter (d_1 = units)
//   conv_result           converter output (23-bit binary)
//   digit_count           digits entered (0..7)
//   busy                  high while CONVERT/CHECK/LOAD
//   freq_word, freq_load  accepted frequency and its one-cycle load strobe
//   range_err             sticky: last commit was rejected
module freq_entry_controller #(
  parameter int unsigned MIN_FREQ     = 1,
  parameter int unsigned MAX_FREQ     = 5000000,
  parameter int unsigned DEFAULT_FREQ = 1000,
  parameter int unsigned CONV_LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        digit_valid,
  input  logic [3:0]  digit_in,
  input  logic        clear,
  input  logic        commit,
  output logic [3:0]  d_1,
  output logic [3:0]  d_2,
  output logic [3:0]  d_3,
  output logic [3:0]  d_4,
  output logic [3:0]  d_5,
  output logic [3:0]  d_6,
  output logic [3:0]  d_7,
  input  logic [22:0] conv_result,
  output logic [2:0]  digit_count,
  output logic        busy,
  output logic [22:0] freq_word,
  output logic        freq_load,
  output logic        range_err
);

  localparam logic [22:0] MIN_W  = 23'(MIN_FREQ);
  localparam logic [22:0] MAX_W  = 23'(MAX_FREQ);
  localparam logic [22:0] DEF_W  = 23'(DEFAULT_FREQ);
  localparam logic [2:0]  LAT_W  = 3'(CONV_LATENCY);

  typedef enum logic [1:0] {
    ENTRY   = 2'd0,
    CONVERT = 2'd1,
    CHECK   = 2'd2,
    LOAD    = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [6:0][3:0]    dig_q, dig_d;       // dig_q[0] = units
  logic [2:0]         cnt_q, cnt_d;
  logic [2:0]         wait_q, wait_d;
  logic [22:0]        res_q, res_d;
  logic [22:0]        freq_word_q, freq_word_d;
  logic               freq_load_q, freq_load_d;
  logic               range_err_q, range_err_d;
  logic               busy_q, busy_d;

  always_comb begin
    state_d     = state_q;
    dig_d       = dig_q;
    cnt_d       = cnt_q;
    wait_d      = wait_q;
    res_d       = res_q;
    freq_word_d = freq_word_q;
    freq_load_d = 1'b0;
    range_err_d = range_err_q;

    case (state_q)
      ENTRY: begin
        // clear > commit > digit_valid; losers in the same cycle are dropped
        if (clear) begin
          dig_d       = '0;
          cnt_d       = 3'd0;
          range_err_d = 1'b0;
        end else if (commit) begin
          if (cnt_q != 3'd0) begin
            state_d = CONVERT;
            wait_d  = LAT_W;
          end
        end else if (digit_valid && (digit_in <= 4'd9) && (cnt_q < 3'd7)) begin
          dig_d = {dig_q[5:0], digit_in};
          cnt_d = cnt_q + 3'd1;
        end
      end

      CONVERT: begin
        wait_d = wait_q - 3'd1;
        if (wait_q == 3'd1) begin
          res_d   = conv_result;
          state_d = CHECK;
        end
      end

      CHECK: begin
        // Converter wraps at 2^23; a millions digit of 8 or 9 is already out
        // of range, so the sampled result is not consulted in that case.
        if ((dig_q[6] >= 4'd8) || (res_q < MIN_W) || (res_q > MAX_W)) begin
          range_err_d = 1'b1;
          state_d     = ENTRY;
        end else begin
          freq_word_d = res_q;
          freq_load_d = 1'b1;
          range_err_d = 1'b0;
          state_d     = LOAD;
        end
      end

      LOAD: begin
        dig_d   = '0;
        cnt_d   = 3'd0;
        state_d = ENTRY;
      end

      default: state_d = ENTRY;
    endcase

    busy_d = (state_d != ENTRY);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ENTRY;
      dig_q       <= '0;
      cnt_q       <= 3'd0;
      wait_q      <= 3'd0;
      res_q       <= 23'd0;
      freq_word_q <= DEF_W;
      freq_load_q <= 1'b0;
      range_err_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      dig_q       <= dig_d;
      cnt_q       <= cnt_d;
      wait_q      <= wait_d;
      res_q       <= res_d;
      freq_word_q <= freq_word_d;
      freq_load_q <= freq_load_d;
      range_err_q <= range_err_d;
      busy_q      <= busy_d;
    end
  end

  assign d_1         = dig_q[0];
  assign d_2         = dig_q[1];
  assign d_3         = dig_q[2];
  assign d_4         = dig_q[3];
  assign d_5         = dig_q[4];
  assign d_6         = dig_q[5];
  assign d_7         = dig_q[6];
  assign digit_count = cnt_q;
  assign busy        = busy_q;
  assign freq_word   = freq_word_q;
  assign freq_load   = freq_load_q;
  assign range_err   = range_err_q;

endmodule

// File: tb/tb_freq_entry_controller.sv
// Directed bench for freq_entry_controller: one instance at default latency,
// one at CONV_LATENCY=4. Each has a behavioural BCD-to-binary converter that
// wraps at 23 bits. Accepted values are queued at commit time and popped when
// freq_load fires.
module tb_freq_entry_controller;

  logic        clk = 1'b0;
  logic        rst_a, rst_b;
  logic        digit_valid, clear, commit;
  logic [3:0]  digit_in;

  logic [3:0]  a1, a2, a3, a4, a5, a6, a7;
  logic [3:0]  b1, b2, b3, b4, b5, b6, b7;
  logic [22:0] conv_a, conv_b, fw_a, fw_b;
  logic [2:0]  cnt_a, cnt_b;
  logic        busy_a, busy_b, ld_a, ld_b, err_a, err_b;
  logic [27:0] dig_a, dig_b;

  int checks = 0;
  int errors = 0;
  logic [22:0] exp_q[$];

  always #5 clk = ~clk;

  assign dig_a = {a7, a6, a5, a4, a3, a2, a1};
  assign dig_b = {b7, b6, b5, b4, b3, b2, b1};

  function automatic logic [22:0] bcd2bin(input logic [27:0] d);
    int v;
    v = 0;
    for (int i = 6; i >= 0; i--) v = v * 10 + int'(d[i*4 +: 4]);
    return 23'(v);
  endfunction

  always_comb conv_a = bcd2bin(dig_a);
  always_comb conv_b = bcd2bin(dig_b);

  freq_entry_controller dut (
    .clk(clk), .rst(rst_a), .digit_valid(digit_valid), .digit_in(digit_in),
    .clear(clear), .commit(commit),
    .d_1(a1), .d_2(a2), .d_3(a3), .d_4(a4), .d_5(a5), .d_6(a6), .d_7(a7),
    .conv_result(conv_a), .digit_count(cnt_a), .busy(busy_a),
    .freq_word(fw_a), .freq_load(ld_a), .range_err(err_a)
  );

  freq_entry_controller #(.CONV_LATENCY(4)) dut4 (
    .clk(clk), .rst(rst_b), .digit_valid(digit_valid), .digit_in(digit_in),
    .clear(clear), .commit(commit),
    .d_1(b1), .d_2(b2), .d_3(b3), .d_4(b4), .d_5(b5), .d_6(b6), .d_7(b7),
    .conv_result(conv_b), .digit_count(cnt_b), .busy(busy_b),
    .freq_word(fw_b), .freq_load(ld_b), .range_err(err_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Scoreboard: every freq_load must match the oldest queued expectation.
  always @(negedge clk) begin
    if (ld_a === 1'b1) begin
      chk("sb_pending_a", 32'(exp_q.size() > 0), 1);
      if (exp_q.size() > 0) chk("sb_word_a", 32'(fw_a), 32'(exp_q.pop_front()));
    end
    if (ld_b === 1'b1) begin
      chk("sb_pending_b", 32'(exp_q.size() > 0), 1);
      if (exp_q.size() > 0) chk("sb_word_b", 32'(fw_b), 32'(exp_q.pop_front()));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic press(input logic [3:0] d);
    digit_valid = 1'b1; digit_in = d;
    step();
    digit_valid = 1'b0;
  endtask

  task automatic do_commit();
    commit = 1'b1;
    step();
    commit = 1'b0;
  endtask

  // After a commit edge: check freq_load/busy over cycles 1..lat+3.
  task automatic watch(input string tag, input int lat, input logic accept, input logic use_b);
    for (int k = 1; k <= lat + 3; k++) begin
      if (k > 1) step();
      chk({tag, "_load"}, 32'(use_b ? ld_b : ld_a), 32'(accept && (k == lat + 2)));
      chk({tag, "_busy"}, 32'(use_b ? busy_b : busy_a),
          32'(k <= lat + (accept ? 2 : 1)));
    end
  endtask

  initial begin
    rst_a = 1'b1; rst_b = 1'b1;
    digit_valid = 1'b0; digit_in = 4'd0; clear = 1'b0; commit = 1'b0;
    step(); step();
    rst_a = 1'b0;
    step();

    // Reset state
    chk("rst_digits", 32'(dig_a), 0);
    chk("rst_count", 32'(cnt_a), 0);
    chk("rst_busy", 32'(busy_a), 0);
    chk("rst_word", 32'(fw_a), 1000);
    chk("rst_load", 32'(ld_a), 0);
    chk("rst_err", 32'(err_a), 0);

    // Basic entry and accept: 1234
    press(1); press(2); press(3); press(4);
    chk("e1234_digits", 32'(dig_a), 32'h0001234);
    chk("e1234_count", 32'(cnt_a), 4);
    exp_q.push_back(23'd1234);
    do_commit();
    watch("c1234", 1, 1'b1, 1'b0);
    chk("c1234_word", 32'(fw_a), 1234);
    chk("c1234_digits", 32'(dig_a), 0);
    chk("c1234_count", 32'(cnt_a), 0);
    chk("c1234_err", 32'(err_a), 0);

    // 9999999 wraps in the converter to an in-range value; must still reject
    for (int i = 0; i < 7; i++) press(9);
    do_commit();
    watch("c9999999", 1, 1'b0, 1'b0);
    chk("c9999999_err", 32'(err_a), 1);
    chk("c9999999_word", 32'(fw_a), 1234);
    chk("c9999999_digits", 32'(dig_a), 32'h9999999);
    chk("c9999999_count", 32'(cnt_a), 7);

    // Full register, invalid digit, below-minimum commit
    rst_a = 1'b1; step(); rst_a = 1'b0;
    for (int i = 1; i <= 8; i++) press(4'(i));
    chk("full_count", 32'(cnt_a), 7);
    chk("full_digits", 32'(dig_a), 32'h1234567);
    press(4'hA);
    chk("bad_digit", 32'(dig_a), 32'h1234567);
    chk("bad_count", 32'(cnt_a), 7);
    clear = 1'b1; step(); clear = 1'b0;
    press(0);
    do_commit();
    watch("c0", 1, 1'b0, 1'b0);
    chk("c0_err", 32'(err_a), 1);
    chk("c0_count", 32'(cnt_a), 1);

    // Empty commit is ignored
    clear = 1'b1; step(); clear = 1'b0;
    chk("clr_err", 32'(err_a), 0);
    do_commit();
    chk("empty_busy", 32'(busy_a), 0);
    step();
    chk("empty_busy2", 32'(busy_a), 0);

    // clear wins over commit
    press(4); press(2);
    clear = 1'b1; commit = 1'b1; step(); clear = 1'b0; commit = 1'b0;
    chk("clrcmt_count", 32'(cnt_a), 0);
    chk("clrcmt_digits", 32'(dig_a), 0);
    chk("clrcmt_busy", 32'(busy_a), 0);

    // commit wins over digit_valid
    press(7); press(7);
    exp_q.push_back(23'd77);
    commit = 1'b1; digit_valid = 1'b1; digit_in = 4'd3;
    step();
    commit = 1'b0; digit_valid = 1'b0;
    chk("cmtdig_count", 32'(cnt_a), 2);
    chk("cmtdig_digits", 32'(dig_a), 32'h77);
    watch("c77", 1, 1'b1, 1'b0);
    chk("c77_word", 32'(fw_a), 77);

    // MAX_FREQ boundary
    press(5); for (int i = 0; i < 6; i++) press(0);
    exp_q.push_back(23'd5000000);
    do_commit();
    watch("cmax", 1, 1'b1, 1'b0);
    chk("cmax_word", 32'(fw_a), 5000000);
    press(5); for (int i = 0; i < 5; i++) press(0); press(1);
    do_commit();
    watch("cmax1", 1, 1'b0, 1'b0);
    chk("cmax1_err", 32'(err_a), 1);
    chk("cmax1_word", 32'(fw_a), 5000000);

    // CONV_LATENCY = 4 instance
    rst_a = 1'b1;
    rst_b = 1'b0;
    step();
    chk("l4_rst_word", 32'(fw_b), 1000);
    press(1); press(0); press(0); press(0);
    exp_q.push_back(23'd1000);
    do_commit();
    watch("l4", 4, 1'b1, 1'b1);
    chk("l4_word", 32'(fw_b), 1000);
    chk("l4_count", 32'(cnt_b), 0);

    // Reset during CONVERT aborts without a load
    press(2); press(0); press(0); press(0);
    do_commit();
    chk("abort_busy1", 32'(busy_b), 1);
    step();
    chk("abort_busy2", 32'(busy_b), 1);
    rst_b = 1'b1; step(); rst_b = 1'b0;
    chk("abort_busy", 32'(busy_b), 0);
    chk("abort_load", 32'(ld_b), 0);
    chk("abort_word", 32'(fw_b), 1000);
    chk("abort_count", 32'(cnt_b), 0);
    chk("abort_digits", 32'(dig_b), 0);
    chk("abort_err", 32'(err_b), 0);
    for (int i = 0; i < 8; i++) begin
      step();
      chk("abort_noload", 32'(ld_b), 0);
    end
    chk("abort_word_end", 32'(fw_b), 1000);

    chk("sb_drained", 32'(exp_q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
